mem_wb_pipe_reg: RTL
====================

// Module: mem_wb_pipe_reg
// PURPOSE
//  Parametrised, clocked MEM->WB pipeline register for the 16-bit datapath. It carries the write-back control
//  fields, ALU result, load data, divide remainder and mov opcode. A 2-entry skid buffer with a valid/ready
//  handshake lets WB stall without a combinational ready path into MEM.
//  Also provides stage flush, bubble-safe RegWrite, a forwarding tap for the hazard unit and a stall counter.
// PARAMETERS
//  DATA_W       16  width of ALU_Result, ReadData, Remainder, WB_Data
//  MOVOP_W      4   width of movOP field
//  REG_ADDR_W   3   destination register index width
//  HAS_REM      1   1: carry Remainder field; 0: field tied to 0, its storage removed
//  STALL_CNT_W  8   width of saturating stall counter
// PORTS
//  clk            in   1            rising-edge clock
//  rst_n          in   1            asynchronous active-low reset
//  flush          in   1            synchronous stage flush (branch/exception)
//  in_valid       in   1            MEM stage presents a valid instruction
//  in_ready       out  1            buffer can accept (registered: !skid_valid)
//  MemToReg_in    in   1            select load data for write-back
//  RegWrite_in    in   1            instruction writes register file
//  Rd_in          in   REG_ADDR_W   destination register
//  ALU_Result     in   DATA_W       ALU result / address
//  ReadData       in   DATA_W       data memory read data
//  Remainder      in   DATA_W       divider remainder
//  movOP_in       in   MOVOP_W      mov-class opcode
//  out_valid      out  1            WB entry valid
//  out_ready      in   1            WB consumes entry this cycle
//  MemToReg_out, Rd_out, ALU_Result_out, ReadData_out, Remainder_out, movOP_out  out  as inputs  head-entry payload
//  RegWrite_out   out  1            head RegWrite AND out_valid
//  WB_Data        out  DATA_W       MemToReg_out ? ReadData_out : ALU_Result_out
//  fwd_valid      out  1            out_valid & RegWrite_out
//  fwd_rd, fwd_data  out  REG_ADDR_W, DATA_W  = Rd_out, WB_Data
//  stall_cnt      out  STALL_CNT_W  saturating count of cycles with out_valid & !out_ready
// BEHAVIOUR
//  - Storage: head entry H (drives outputs), skid entry S. accept = in_valid & in_ready; pop = out_valid & out_ready.
//  - Reset (rst_n low, async): H.valid=S.valid=0, all payload regs 0, stall_cnt=0; so in_ready=1, out_valid=0,
//    RegWrite_out=0, WB_Data=0. Inputs are ignored while rst_n is low; the first accept is on the first edge after release.
//  - Latency: with H empty, or H popping in the same cycle, an accepted input appears on outputs one clock later.
//  - Per-edge update (flush=0):
//    H empty:           accept -> H<=in.
//    H full, pop:       S full -> H<=S, S.valid<=0 (in_ready was 0, no accept); S empty -> accept ? H<=in : H.valid<=0.
//    H full, no pop:    accept -> S<=in (in_ready falls next cycle). Otherwise hold.
//  - Invariant: S.valid implies H.valid. Ordering is strictly FIFO. Payload is never altered while valid and stalled.
//  - Flush: clears H.valid and S.valid at the edge. Flush overrides a same-cycle accept and pop; the flushed input is dropped.
//    Payload regs may keep stale values, but every qualified output (RegWrite_out, fwd_valid) reads 0.
//  - in_ready depends only on registers (no in->out combinational path). out_valid = H.valid.
//  - HAS_REM=0: Remainder_out constant 0; no flops are inferred for it.
//  - stall_cnt: +1 per cycle with out_valid & !out_ready and saturates at all-ones. Flush does not clear it; only reset does.
//  - WB_Data/fwd_* are combinational from H; no arithmetic, all fields pass through at full width.
// STRUCTURE
//  - Shared package cpu_pkg: DATA_W/REG_ADDR_W/MOVOP_W defaults, typedef struct mem_wb_payload_t
//    {MemToReg, RegWrite, Rd, ALU_Result, ReadData, Remainder, movOP}, movOP encodings.
//  - One sub-module: skid_buf2 #(W) handling the generic 2-entry valid/ready storage of a packed payload.
//    The top level adds RegWrite gating, the WB_Data mux, the forwarding tap and stall_cnt.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream with H,S full -> out_valid=0, RegWrite_out=0, in_ready=1, stall_cnt=0 immediately, without a clock edge.
//  2 Streaming: out_ready=1, feed ALU_Result 0x0001..0x0010 back-to-back -> same sequence on ALU_Result_out one cycle later, in_ready constant 1.
//  3 Stall/skid: H=0x00AA, out_ready=0, accept 0x00BB -> in_ready=0 next cycle; hold 5 cycles; then out_ready=1
//    -> 0x00AA then 0x00BB in order; stall_cnt=6; in_ready=1 once S drains.
//  4 Flush: H, S full, flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, fwd_valid=0; the flushed input never appears.
//  5 WB mux/forward: MemToReg=1, ReadData=0x1234, ALU=0x5678, Rd=5, RegWrite=1 -> WB_Data=fwd_data=0x1234, fwd_rd=5;
//    the same with MemToReg=0 -> 0x5678.
//  6 Saturation/param: STALL_CNT_W=2, stall 10 cycles -> stall_cnt=3; HAS_REM=0 build, Remainder=0xFFFF -> Remainder_out=0.

Source files
------------

// File: rtl/mem_wb_pipe_reg_pkg.sv
// Shared CPU datapath definitions: default widths, MEM->WB payload layout, mov opcodes.
package cpu_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned MOVOP_W     = 4;
    localparam int unsigned REG_ADDR_W  = 3;
    localparam int unsigned STALL_CNT_W = 8;

    // MEM->WB payload at the default datapath widths
    typedef struct packed {
        logic                  MemToReg;
        logic                  RegWrite;
        logic [REG_ADDR_W-1:0] Rd;
        logic [DATA_W-1:0]     ALU_Result;
        logic [DATA_W-1:0]     ReadData;
        logic [DATA_W-1:0]     Remainder;
        logic [MOVOP_W-1:0]    movOP;
    } mem_wb_payload_t;

    // mov-class opcode encodings
    typedef enum logic [MOVOP_W-1:0] {
        MOV_NONE = 4'h0,
        MOV_RR   = 4'h1,
        MOV_LO   = 4'h2,
        MOV_HI   = 4'h3,
        MOV_REM  = 4'h4
    } mov_op_e;

    // Flattened payload width; the remainder field disappears when not carried
    function automatic int unsigned payload_w(input int unsigned dw,
                                              input int unsigned mw,
                                              input int unsigned aw,
                                              input int unsigned has_rem);
        return 2 + aw + (2 * dw) + mw + ((has_rem != 0) ? dw : 0);
    endfunction

endpackage

// File: rtl/mem_wb_pipe_reg_if.sv
// MEM->WB bus: MEM-side instruction fields with handshake, WB-side payload, forwarding tap, stall counter.
interface mem_wb_pipe_reg_if #(
    parameter int unsigned DATA_W      = cpu_pkg::DATA_W,
    parameter int unsigned MOVOP_W     = cpu_pkg::MOVOP_W,
    parameter int unsigned REG_ADDR_W  = cpu_pkg::REG_ADDR_W,
    parameter int unsigned STALL_CNT_W = cpu_pkg::STALL_CNT_W
);
    // MEM side
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic                   MemToReg_in;
    logic                   RegWrite_in;
    logic [REG_ADDR_W-1:0]  Rd_in;
    logic [DATA_W-1:0]      ALU_Result;
    logic [DATA_W-1:0]      ReadData;
    logic [DATA_W-1:0]      Remainder;
    logic [MOVOP_W-1:0]     movOP_in;

    // WB side
    logic                   out_valid;
    logic                   out_ready;
    logic                   MemToReg_out;
    logic                   RegWrite_out;
    logic [REG_ADDR_W-1:0]  Rd_out;
    logic [DATA_W-1:0]      ALU_Result_out;
    logic [DATA_W-1:0]      ReadData_out;
    logic [DATA_W-1:0]      Remainder_out;
    logic [MOVOP_W-1:0]     movOP_out;
    logic [DATA_W-1:0]      WB_Data;

    // hazard-unit tap and statistics
    logic                   fwd_valid;
    logic [REG_ADDR_W-1:0]  fwd_rd;
    logic [DATA_W-1:0]      fwd_data;
    logic [STALL_CNT_W-1:0] stall_cnt;

    // Driver of MEM-side fields and WB ready
    modport master (
        output flush, in_valid, MemToReg_in, RegWrite_in, Rd_in,
               ALU_Result, ReadData, Remainder, movOP_in, out_ready,
        input  in_ready, out_valid, MemToReg_out, RegWrite_out, Rd_out,
               ALU_Result_out, ReadData_out, Remainder_out, movOP_out,
               WB_Data, fwd_valid, fwd_rd, fwd_data, stall_cnt
    );

    // The pipeline register itself
    modport slave (
        input  flush, in_valid, MemToReg_in, RegWrite_in, Rd_in,
               ALU_Result, ReadData, Remainder, movOP_in, out_ready,
        output in_ready, out_valid, MemToReg_out, RegWrite_out, Rd_out,
               ALU_Result_out, ReadData_out, Remainder_out, movOP_out,
               WB_Data, fwd_valid, fwd_rd, fwd_data, stall_cnt
    );

endinterface

// File: rtl/mem_wb_pipe_reg_skid_buf2.sv
// Generic 2-entry valid/ready skid buffer; head entry drives the output, ready is a flop.
module skid_buf2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic         r_h_valid;
    logic         r_s_valid;
    logic         r_ready;
    logic [W-1:0] r_h_data;
    logic [W-1:0] r_s_data;

    logic         w_h_valid;
    logic         w_s_valid;
    logic         w_ready;
    logic [W-1:0] w_h_data;
    logic [W-1:0] w_s_data;
    logic         w_accept;
    logic         w_pop;

    assign w_accept = i_valid & r_ready;
    assign w_pop    = r_h_valid & i_ready;

    // Next-state: fill head first, spill into skid only while head is stalled
    always_comb begin
        w_h_valid = r_h_valid;
        w_s_valid = r_s_valid;
        w_h_data  = r_h_data;
        w_s_data  = r_s_data;

        if (i_flush) begin
            w_h_valid = 1'b0;
            w_s_valid = 1'b0;
        end else if (!r_h_valid) begin
            if (w_accept) begin
                w_h_valid = 1'b1;
                w_h_data  = i_data;
            end
        end else if (w_pop) begin
            if (r_s_valid) begin
                w_h_data  = r_s_data;
                w_s_valid = 1'b0;
            end else if (w_accept) begin
                w_h_data  = i_data;
            end else begin
                w_h_valid = 1'b0;
            end
        end else if (w_accept) begin
            w_s_valid = 1'b1;
            w_s_data  = i_data;
        end

        w_ready = ~w_s_valid;
    end

    // State register; ready mirrors an empty skid slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_ready   <= 1'b1;
            r_h_data  <= '0;
            r_s_data  <= '0;
        end else begin
            r_h_valid <= w_h_valid;
            r_s_valid <= w_s_valid;
            r_ready   <= w_ready;
            r_h_data  <= w_h_data;
            r_s_data  <= w_s_data;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_h_valid;
    assign o_data  = r_h_data;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: skid-buffered payload, bubble-safe RegWrite, WB mux, forward tap, stall counter.
module mem_wb_pipe_reg #(
    parameter int unsigned DATA_W      = cpu_pkg::DATA_W,
    parameter int unsigned MOVOP_W     = cpu_pkg::MOVOP_W,
    parameter int unsigned REG_ADDR_W  = cpu_pkg::REG_ADDR_W,
    parameter int unsigned HAS_REM     = 1,
    parameter int unsigned STALL_CNT_W = cpu_pkg::STALL_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mem_wb_pipe_reg_if.slave        bus
);
    import cpu_pkg::*;

    localparam int unsigned PW = payload_w(DATA_W, MOVOP_W, REG_ADDR_W, HAS_REM);

    logic [PW-1:0]          w_in_pl;
    logic [PW-1:0]          w_out_pl;
    logic                   w_h_valid;
    logic                   w_ready;

    logic                   w_h_memtoreg;
    logic                   w_h_regwrite;
    logic [REG_ADDR_W-1:0]  w_h_rd;
    logic [DATA_W-1:0]      w_h_alu;
    logic [DATA_W-1:0]      w_h_rdata;
    logic [DATA_W-1:0]      w_h_rem;
    logic [MOVOP_W-1:0]     w_h_movop;
    logic [DATA_W-1:0]      w_wb_data;
    logic                   w_regwrite_q;

    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Pack/unpack; without a remainder field it never reaches the buffer
    generate
        if (HAS_REM != 0) begin : g_rem
            assign w_in_pl = {bus.MemToReg_in, bus.RegWrite_in, bus.Rd_in,
                              bus.ALU_Result, bus.ReadData, bus.Remainder, bus.movOP_in};
            assign {w_h_memtoreg, w_h_regwrite, w_h_rd,
                    w_h_alu, w_h_rdata, w_h_rem, w_h_movop} = w_out_pl;
        end else begin : g_norem
            assign w_in_pl = {bus.MemToReg_in, bus.RegWrite_in, bus.Rd_in,
                              bus.ALU_Result, bus.ReadData, bus.movOP_in};
            assign {w_h_memtoreg, w_h_regwrite, w_h_rd,
                    w_h_alu, w_h_rdata, w_h_movop} = w_out_pl;
            assign w_h_rem = '0;
        end
    endgenerate

    skid_buf2 #(
        .W (PW)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.flush),
        .i_valid (bus.in_valid),
        .i_data  (w_in_pl),
        .o_ready (w_ready),
        .o_valid (w_h_valid),
        .o_data  (w_out_pl),
        .i_ready (bus.out_ready)
    );

    // RegWrite never escapes from a bubble or flushed entry
    assign w_regwrite_q = w_h_regwrite & w_h_valid;
    assign w_wb_data    = w_h_memtoreg ? w_h_rdata : w_h_alu;

    // Saturating count of cycles where WB holds a valid entry it does not consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_h_valid && !bus.out_ready && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign bus.in_ready       = w_ready;
    assign bus.out_valid      = w_h_valid;
    assign bus.MemToReg_out   = w_h_memtoreg;
    assign bus.RegWrite_out   = w_regwrite_q;
    assign bus.Rd_out         = w_h_rd;
    assign bus.ALU_Result_out = w_h_alu;
    assign bus.ReadData_out   = w_h_rdata;
    assign bus.Remainder_out  = w_h_rem;
    assign bus.movOP_out      = w_h_movop;
    assign bus.WB_Data        = w_wb_data;
    assign bus.fwd_valid      = w_h_valid & w_regwrite_q;
    assign bus.fwd_rd         = w_h_rd;
    assign bus.fwd_data       = w_wb_data;
    assign bus.stall_cnt      = r_stall_cnt;

endmodule
